// File: rtl/input_conditioner_if.sv
// Raw pushbutton/switch inputs and their debounced, pulse-decoded outputs.
interface input_conditioner_if;
    logic [3:0] btn_n;
    logic [2:0] sw_n;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [2:0] ball_angle;
    logic       angle_changed;

    modport master (
        output btn_n, sw_n,
        input  btn_level, btn_press, btn_release, ball_angle, angle_changed
    );

    modport slave (
        input  btn_n, sw_n,
        output btn_level, btn_press, btn_release, ball_angle, angle_changed
    );
endinterface

// File: rtl/input_conditioner.sv
// Seven identical channels (4 paddle buttons, 3 angle switches): 2-flop sync,
// inversion, debounce counter and stable-state register, plus edge pulses.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CNT_W           = 17
) (
    input logic                 clk,
    input logic                 rst_n,
    input_conditioner_if.slave  bus
);
    localparam int              NCH     = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   sync1_q, sync1_d;
    logic [NCH-1:0]   sync2_q, sync2_d;
    logic [NCH-1:0]   synced;
    logic [NCH-1:0]   stable_q, stable_d;
    logic [NCH-1:0]   accept;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [3:0]       press_q, press_d;
    logic [3:0]       release_q, release_d;
    logic             chg_q, chg_d;

    assign raw    = {bus.sw_n, bus.btn_n};
    // Inversion sits after the second flop so the synchronizer is a pure flop pair.
    assign synced = ~sync2_q;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        accept   = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (synced[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = synced[i];
                cnt_d[i]    = '0;
                accept[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        press_d   = accept[3:0] & synced[3:0];
        release_d = accept[3:0] & ~synced[3:0];
        chg_d     = |accept[6:4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            chg_q     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            chg_q     <= chg_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.btn_level     = stable_q[3:0];
    assign bus.ball_angle    = stable_q[6:4];
    assign bus.btn_press     = press_q;
    assign bus.btn_release   = release_q;
    assign bus.angle_changed = chg_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner at DEBOUNCE_CYCLES=4, plus a DEBOUNCE_CYCLES=1 instance.
module tb_input_conditioner;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    input_conditioner_if bus ();
    input_conditioner_if bus1 ();

    assign bus1.btn_n = bus.btn_n;
    assign bus1.sw_n  = bus.sw_n;

    input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    input_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        logic [3:0] btn_n;
        logic [2:0] sw_n;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [2:0] ang;
        logic       chg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] b, input logic [2:0] s, input logic [3:0] l,
                       input logic [3:0] p, input logic [3:0] r, input logic [2:0] a,
                       input logic c, input int reps);
        vec_t v;
        v.btn_n = b; v.sw_n = s; v.lvl = l; v.prs = p; v.rel = r; v.ang = a; v.chg = c;
        for (int k = 0; k < reps; k++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] l, input logic [3:0] p,
                           input logic [3:0] r, input logic [2:0] a, input logic c);
        chk({tag, " btn_level"},     {4'b0, bus.btn_level},     {4'b0, l});
        chk({tag, " btn_press"},     {4'b0, bus.btn_press},     {4'b0, p});
        chk({tag, " btn_release"},   {4'b0, bus.btn_release},   {4'b0, r});
        chk({tag, " ball_angle"},    {5'b0, bus.ball_angle},    {5'b0, a});
        chk({tag, " angle_changed"}, {7'b0, bus.angle_changed}, {7'b0, c});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press and release of one button must never coincide.
    always @(negedge clk) begin
        if (rst_n) begin
            n_chk++;
            if ((bus.btn_press & bus.btn_release) != 4'b0) begin
                n_fail++;
                $display("FAIL press_release_overlap: press %b release %b, required no common bit",
                         bus.btn_press, bus.btn_release);
            end
        end
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.btn_n = 4'b1111;
        bus.sw_n  = 3'b111;

        // Edge k (counted from reset release) is sampled after record k-1 is applied.
        add(4'b1110, 3'b111, 4'b0000, 4'b0000, 4'b0000, 3'b000, 1'b0, 5);
        add(4'b1110, 3'b111, 4'b0001, 4'b0001, 4'b0000, 3'b000, 1'b0, 1);
        add(4'b1110, 3'b111, 4'b0001, 4'b0000, 4'b0000, 3'b000, 1'b0, 1);
        add(4'b0000, 3'b111, 4'b0001, 4'b0000, 4'b0000, 3'b000, 1'b0, 5);
        add(4'b0000, 3'b111, 4'b1111, 4'b1110, 4'b0000, 3'b000, 1'b0, 1);
        add(4'b0000, 3'b111, 4'b1111, 4'b0000, 4'b0000, 3'b000, 1'b0, 1);
        add(4'b1111, 3'b111, 4'b1111, 4'b0000, 4'b0000, 3'b000, 1'b0, 5);
        add(4'b1111, 3'b111, 4'b0000, 4'b0000, 4'b1111, 3'b000, 1'b0, 1);
        add(4'b1111, 3'b111, 4'b0000, 4'b0000, 4'b0000, 3'b000, 1'b0, 1);
        add(4'b1111, 3'b010, 4'b0000, 4'b0000, 4'b0000, 3'b000, 1'b0, 5);
        add(4'b1111, 3'b010, 4'b0000, 4'b0000, 4'b0000, 3'b101, 1'b1, 1);
        add(4'b1111, 3'b010, 4'b0000, 4'b0000, 4'b0000, 3'b101, 1'b0, 1);
        // btn_n[2] low for 3 cycles only: counter reaches 3 but never accepts.
        add(4'b1011, 3'b010, 4'b0000, 4'b0000, 4'b0000, 3'b101, 1'b0, 3);
        add(4'b1111, 3'b010, 4'b0000, 4'b0000, 4'b0000, 3'b101, 1'b0, 8);

        #50;
        chk_all("reset", 4'b0, 4'b0, 4'b0, 3'b0, 1'b0);
        chk("reset dut1 btn_level", {4'b0, bus1.btn_level}, 8'h00);

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.btn_n = vecs[i].btn_n;
            bus.sw_n  = vecs[i].sw_n;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel,
                    vecs[i].ang, vecs[i].chg);
            if (i == 1) begin
                chk("n1 edge2 btn_level", {4'b0, bus1.btn_level}, 8'h00);
            end
            if (i == 2) begin
                chk("n1 edge3 btn_level", {4'b0, bus1.btn_level}, 8'h01);
                chk("n1 edge3 btn_press", {4'b0, bus1.btn_press}, 8'h01);
            end
        end

        // Bounce on btn_n[1]: 0,1,0 then held low; level rises at the 6th edge of the final low.
        bus.btn_n = 4'b1101; step();
        bus.btn_n = 4'b1111; step();
        bus.btn_n = 4'b1101;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 5) chk_all("bounce e5", 4'b0000, 4'b0000, 4'b0000, 3'b101, 1'b0);
            if (e == 6) chk_all("bounce e6", 4'b0010, 4'b0010, 4'b0000, 3'b101, 1'b0);
            if (e == 7) chk_all("bounce e7", 4'b0010, 4'b0000, 4'b0000, 3'b101, 1'b0);
        end

        // Swap: release btn1, press btn3 in the same cycle.
        bus.btn_n = 4'b0111;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 6) chk_all("swap e6", 4'b1000, 4'b1000, 4'b0010, 3'b101, 1'b0);
        end

        // Start releasing btn3, then reset mid-count.
        bus.btn_n = 4'b1111;
        for (int e = 1; e <= 3; e++) step();
        chk_all("midcount", 4'b1000, 4'b0000, 4'b0000, 3'b101, 1'b0);
        #5;
        rst_n = 1'b0;
        #1;
        chk_all("async reset", 4'b0000, 4'b0000, 4'b0000, 3'b000, 1'b0);
        bus.btn_n = 4'b0111;
        step();
        step();
        chk_all("held reset", 4'b0000, 4'b0000, 4'b0000, 3'b000, 1'b0);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 5) chk_all("repress e5", 4'b0000, 4'b0000, 4'b0000, 3'b000, 1'b0);
            if (e == 6) chk_all("repress e6", 4'b1000, 4'b1000, 4'b0000, 3'b101, 1'b1);
            if (e == 7) chk_all("repress e7", 4'b1000, 4'b0000, 4'b0000, 3'b101, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 65536, number of consecutive stable synchronized samples required to accept a level change (about 2.6 ms at 25.125 MHz).
REQ-002 Parameter: CNT_W, default 17, width of each debounce counter; SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 Port: clk  input  1  system clock, 25.125 MHz pixel clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: btn_n  input  4  raw active-low paddle buttons, asynchronous to clk: [0] left_up, [1] left_down, [2] right_up, [3] right_down.
REQ-006 Port: sw_n  input  3  raw active-low ball-angle switches, asynchronous to clk.
REQ-007 Port: btn_level  output  4  debounced active-high button state, bit order as btn_n.
REQ-008 Port: btn_press  output  4  one-cycle pulse on each debounced 0->1 transition of btn_level.
REQ-009 Port: btn_release  output  4  one-cycle pulse on each debounced 1->0 transition of btn_level.
REQ-010 Port: ball_angle  output  3  debounced active-high switch state.
REQ-011 Port: angle_changed  output  1  one-cycle pulse when any ball_angle bit changes.

Function
REQ-012 Each of the 7 channels (4 buttons, 3 switches) SHALL be independent and identical: inversion, 2-flop synchronizer, debounce counter, stable-state register.
REQ-013 Synchronizer SHALL be two clk flops per channel, with no logic between them; the inversion SHALL follow the second flop.
REQ-014 Debounce per channel, at each clk edge: if the synchronized value equals the stable value, the counter SHALL clear to 0.
REQ-015 If the values differ and counter = DEBOUNCE_CYCLES-1, the stable value SHALL take the synchronized value and the counter SHALL clear to 0.
REQ-016 If the values differ and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-017 The counter SHALL never wrap; by REQ-002 and REQ-015 it never exceeds DEBOUNCE_CYCLES-1.
REQ-018 Latency: a raw change held stable before edge 1 SHALL appear on btn_level/ball_angle at edge DEBOUNCE_CYCLES+2, exactly.
REQ-019 Glitch rejection: any reversion to the stable value before acceptance SHALL clear the counter, so the full DEBOUNCE_CYCLES run restarts.
REQ-020 btn_press[i] SHALL assert at the same edge btn_level[i] rises, for exactly one cycle; btn_release[i] likewise on falls.
REQ-021 Simultaneous transitions on multiple channels SHALL produce simultaneous pulses; no arbitration.
REQ-022 btn_press[i] and btn_release[i] SHALL never be high together.
REQ-023 angle_changed SHALL assert for one cycle at the edge where any ball_angle bit updates, including several bits in the same cycle.
REQ-024 All outputs SHALL be registered, with no combinational path from btn_n/sw_n to outputs.
REQ-025 DEBOUNCE_CYCLES = 1 SHALL be legal, giving a latency of 3 edges.

Reset
REQ-026 While rst_n = 0, all synchronizer flops SHALL be 1 (released level).
REQ-027 While rst_n = 0, all counters SHALL be 0 and all stable values 0.
REQ-028 While rst_n = 0, btn_level, btn_press, btn_release, ball_angle and angle_changed SHALL all be 0.
REQ-029 Reset assertion SHALL take effect immediately, without a clock, and abort any in-progress count with no pulse emitted.
REQ-030 Reset SHALL be deasserted synchronously to clk by the instantiating top (gated by PLL lock).
REQ-031 If an input is held pressed through reset release, it SHALL be accepted after DEBOUNCE_CYCLES+2 edges and SHALL generate btn_press.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 btn_n[0] 1->0 held -> btn_level[0]=1 and btn_press[0]=1 at edge 6 only; btn_press[0]=0 at edge 7.
REQ-033 btn_n[2] low for 3 cycles, then high -> btn_level stays 0000; btn_press never asserts.
REQ-034 btn_n[1] bounces 0,1,0 at 1-cycle intervals, then held low -> btn_level[1] rises 6 edges after the last transition.
REQ-035 sw_n 111->010 held -> ball_angle=101 at edge 6; angle_changed high for exactly that one cycle.
REQ-036 btn_level[3]=1, then rst_n pulsed low mid-count of a release -> all outputs 0 immediately; btn_n[3] still low -> re-press pulse 6 edges after reset release.
REQ-037 All four btn_n released together from pressed -> btn_release=1111 for one cycle at edge 6; btn_press=0000 throughout.
